reflet_uart_loader: RTL and testbench

Serial boot loader that sits upstream of the 8-bit controller's 128-byte instruction memory (0x00-0x7F). It receives a framed program image over a UART rx line and writes it byte-by-byte into the instruction RAM's write port. The CPU is held in reset until the image is complete, then released. Only one image load is accepted per reset.

---
 rtl/reflet_uart_loader_if.sv | 12 +
 rtl/reflet_uart_loader.sv | 195 +++++++++++++++++++
 tb/tb_reflet_uart_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/reflet_uart_loader_if.sv
// Instruction-memory write port driven by the UART boot loader.
// The loader uses the master side; the instruction RAM uses the slave side.
interface reflet_uart_loader_if #(
   parameter int addr_size = 7
);
   logic [addr_size-1:0] mem_addr;
   logic [7:0]           mem_data;
   logic                 mem_we;

   modport master (output mem_addr, output mem_data, output mem_we);
   modport slave  (input  mem_addr, input  mem_data, input  mem_we);
endinterface

// File: rtl/reflet_uart_loader.sv
// UART boot loader: receives a 0xA5 / length / payload image and writes it into instruction RAM.
// Optional trailing checksum byte is enabled by defining REFLET_LOADER_CHECKSUM_EN.
module reflet_uart_loader #(
   parameter int clk_freq  = 1000000,
   parameter int baud_rate = 9600,
   parameter int mem_size  = 128,
   parameter int addr_size = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   reflet_uart_loader_if.master mem,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 error
);
   localparam int bit_div     = clk_freq / baud_rate;
   localparam int bit_period  = (bit_div < 4) ? 4 : bit_div;
   localparam int half_period = bit_period / 2;
   localparam int cnt_w       = $clog2(bit_period);
   localparam logic [cnt_w-1:0]   cnt_one   = 1;
   localparam logic [cnt_w-1:0]   cnt_bit   = cnt_w'(bit_period - 1);
   localparam logic [cnt_w-1:0]   cnt_half  = cnt_w'(half_period - 1);
   localparam logic [addr_size:0] idx_one   = 1;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t        rx_state_reg;
   logic [1:0]       rx_sync_reg;
   logic             rx_prev_reg;
   logic [cnt_w-1:0] cnt_reg;
   logic [2:0]       bit_cnt_reg;
   logic [7:0]       shift_reg;
   logic             byte_valid_reg;
   logic             frame_err_reg;
   logic             rx_s;
   logic [7:0]       rx_byte;

   assign rx_s    = rx_sync_reg[1];
   assign rx_byte = shift_reg;

   // Receiver: samples at bit centres measured from the synchronized start edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sync_reg    <= 2'b11;
         rx_prev_reg    <= 1'b1;
         rx_state_reg   <= RX_IDLE;
         cnt_reg        <= '0;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         byte_valid_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
      end else begin
         rx_sync_reg    <= {rx_sync_reg[0], rx};
         rx_prev_reg    <= rx_s;
         byte_valid_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         case (rx_state_reg)
            RX_IDLE: begin
               cnt_reg <= '0;
               if (rx_prev_reg && !rx_s) rx_state_reg <= RX_START;
            end
            RX_START: begin
               if (cnt_reg == cnt_half) begin
                  cnt_reg      <= '0;
                  bit_cnt_reg  <= '0;
                  rx_state_reg <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_reg <= cnt_reg + cnt_one;
               end
            end
            RX_DATA: begin
               if (cnt_reg == cnt_bit) begin
                  cnt_reg     <= '0;
                  shift_reg   <= {rx_s, shift_reg[7:1]};
                  bit_cnt_reg <= bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) rx_state_reg <= RX_STOP;
               end else begin
                  cnt_reg <= cnt_reg + cnt_one;
               end
            end
            RX_STOP: begin
               if (cnt_reg == cnt_bit) begin
                  cnt_reg        <= '0;
                  rx_state_reg   <= RX_IDLE;
                  byte_valid_reg <= rx_s;
                  frame_err_reg  <= !rx_s;
               end else begin
                  cnt_reg <= cnt_reg + cnt_one;
               end
            end
            default: rx_state_reg <= RX_IDLE;
         endcase
      end
   end

   typedef enum logic [2:0] {
      WAIT_MAGIC,
      GET_LEN,
      GET_DATA,
`ifdef REFLET_LOADER_CHECKSUM_EN
      CHECK,
`endif
      FINISH
   } state_t;

   state_t               state_reg, state_next;
   logic [addr_size:0]   len_reg, index_reg;
   logic [addr_size-1:0] mem_addr_reg;
   logic [7:0]           mem_data_reg;
   logic                 mem_we_reg, error_reg, done_reg;
   logic                 len_ok, is_magic, last_byte;
   logic                 write_en, len_load, error_set, error_clr, done_next;
`ifdef REFLET_LOADER_CHECKSUM_EN
   logic [7:0]           sum_reg;
`endif

   assign len_ok    = (rx_byte != 8'd0) && (int'(rx_byte) <= mem_size);
   assign is_magic  = (rx_byte == 8'hA5);
   assign last_byte = (index_reg == (len_reg - idx_one));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= WAIT_MAGIC;
         len_reg      <= '0;
         index_reg    <= '0;
         mem_addr_reg <= '0;
         mem_data_reg <= '0;
         mem_we_reg   <= 1'b0;
         error_reg    <= 1'b0;
         done_reg     <= 1'b0;
`ifdef REFLET_LOADER_CHECKSUM_EN
         sum_reg      <= '0;
`endif
      end else begin
         state_reg  <= state_next;
         mem_we_reg <= write_en;
         done_reg   <= done_next;
         if (len_load) begin
            len_reg   <= (addr_size + 1)'(rx_byte);
            index_reg <= '0;
         end else if (write_en) begin
            index_reg <= index_reg + idx_one;
         end
         if (write_en) begin
            mem_addr_reg <= index_reg[addr_size-1:0];
            mem_data_reg <= rx_byte;
         end
         if (error_set)      error_reg <= 1'b1;
         else if (error_clr) error_reg <= 1'b0;
`ifdef REFLET_LOADER_CHECKSUM_EN
         if (len_load)      sum_reg <= '0;
         else if (write_en) sum_reg <= sum_reg + rx_byte;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         WAIT_MAGIC: if (byte_valid_reg && is_magic) state_next = GET_LEN;
         GET_LEN:    if (byte_valid_reg) state_next = len_ok ? GET_DATA : WAIT_MAGIC;
`ifdef REFLET_LOADER_CHECKSUM_EN
         GET_DATA:   if (byte_valid_reg && last_byte) state_next = CHECK;
         CHECK:      if (byte_valid_reg) state_next = (rx_byte == sum_reg) ? FINISH : WAIT_MAGIC;
`else
         GET_DATA:   if (byte_valid_reg && last_byte) state_next = FINISH;
`endif
         FINISH:     state_next = FINISH;
         default:    state_next = WAIT_MAGIC;
      endcase
      // A broken frame abandons the image unless it is already complete.
      if (frame_err_reg && state_reg != FINISH) state_next = WAIT_MAGIC;
   end

   always_comb begin
      write_en  = (state_reg == GET_DATA) && byte_valid_reg;
      len_load  = (state_reg == GET_LEN) && byte_valid_reg && len_ok;
      error_clr = (state_reg == WAIT_MAGIC) && byte_valid_reg && is_magic;
      error_set = (frame_err_reg && state_reg != FINISH)
               || ((state_reg == GET_LEN) && byte_valid_reg && !len_ok);
`ifdef REFLET_LOADER_CHECKSUM_EN
      error_set = error_set || ((state_reg == CHECK) && byte_valid_reg && (rx_byte != sum_reg));
`endif
      // Registered one cycle late so release follows the final strobe.
      done_next = (state_reg == FINISH);
   end

   assign mem.mem_addr = mem_addr_reg;
   assign mem.mem_data = mem_data_reg;
   assign mem.mem_we   = mem_we_reg;
   assign done         = done_reg;
   assign cpu_hold     = !done_reg;
   assign error        = error_reg;
endmodule

// File: tb/tb_reflet_uart_loader.sv
// Scoreboard bench for reflet_uart_loader: expected RAM writes are queued as bytes are sent,
// a negedge monitor pops and compares every mem_we strobe.
module tb_reflet_uart_loader;
   localparam int BP = 16;  // 1 MHz / 62500 baud keeps the 128-byte image short

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rx = 1'b1;
   logic cpu_hold, done, error;

   reflet_uart_loader_if #(.addr_size(7)) mem_bus ();

   reflet_uart_loader #(
      .clk_freq (1000000),
      .baud_rate(62500),
      .mem_size (128),
      .addr_size(7)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .rx      (rx),
      .mem     (mem_bus.master),
      .cpu_hold(cpu_hold),
      .done    (done),
      .error   (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        exp_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] payload[128];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: scoreboard pop on each strobe, strobe width, release timing, hold/done coupling.
   logic we_prev = 1'b0;
   logic done_prev = 1'b0;
   int   strobe_age = 1000;
   always @(negedge clk) begin
      if (reset) begin
         we_prev    = 1'b0;
         done_prev  = 1'b0;
         strobe_age = 1000;
      end else begin
         if (mem_bus.mem_we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 32'(mem_bus.mem_addr), 32'hFFFF);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("write_addr", 32'(mem_bus.mem_addr), 32'(e.addr));
               check("write_data", 32'(mem_bus.mem_data), 32'(e.data));
               $display("write addr %02h data %02h (expected %02h/%02h)",
                        mem_bus.mem_addr, mem_bus.mem_data, e.addr, e.data);
            end
            check("we_single_cycle", 32'(we_prev), 32'd0);
         end
`ifndef REFLET_LOADER_CHECKSUM_EN
         if (done && !done_prev) check("done_after_last_strobe", 32'(strobe_age), 32'd0);
`endif
         if (done != done_prev || cpu_hold == done) check("cpu_hold_vs_done", 32'(cpu_hold), 32'(!done));
         strobe_age = mem_bus.mem_we ? 0 : strobe_age + 1;
         we_prev    = mem_bus.mem_we;
         done_prev  = done;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
      check("rst_mem_data", 32'(mem_bus.mem_data), 32'd0);
      check("rst_mem_we",   32'(mem_bus.mem_we), 32'd0);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rst_done",     32'(done), 32'd0);
      check("rst_error",    32'(error), 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      logic [7:0] v;
      v  = b;
      rx = 1'b0;
      repeat (BP) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = v[i];
         repeat (BP) @(negedge clk);
      end
      rx = stop_bit;
      repeat (BP) @(negedge clk);
      rx = 1'b1;
      repeat (2 * BP) @(negedge clk);
      $display("sent byte %02h stop %0d", b, stop_bit);
   endtask

   // Payload byte with its expected write queued before it goes out.
   task automatic send_data(input int idx, input logic [7:0] b);
      wr_t e;
      e.addr = 7'(idx);
      e.data = b;
      exp_q.push_back(e);
      send_byte(b, 1'b1);
   endtask

   task automatic send_image(input int n);
      logic [7:0] sum;
      sum = 8'd0;
      send_byte(8'hA5, 1'b1);
      send_byte(8'(n), 1'b1);
      for (int i = 0; i < n; i++) begin
         send_data(i, payload[i]);
         sum = sum + payload[i];
      end
`ifdef REFLET_LOADER_CHECKSUM_EN
      send_byte(sum, 1'b1);
`else
      if (sum == 8'hXX) $display("checksum disabled");
`endif
   endtask

   task automatic check_status(input string tag, input logic d, input logic e);
      check({tag, "_done"},     32'(done), 32'(d));
      check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!d));
      check({tag, "_error"},    32'(error), 32'(e));
      check({tag, "_pending"},  32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // 1: basic three-byte image
      do_reset();
      payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
      send_image(3);
      check_status("basic", 1'b1, 1'b0);

      // 2: noise before the magic byte
      do_reset();
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      check_status("noise", 1'b0, 1'b0);
      payload[0] = 8'h7E;
      send_image(1);
      check_status("single", 1'b1, 1'b0);

      // 3: length boundaries
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      check_status("len0", 1'b0, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h81, 1'b1);
      check_status("len129", 1'b0, 1'b1);
      for (int i = 0; i < 128; i++) payload[i] = 8'((i * 37 + 5) & 8'hFF);
      send_image(128);
      check_status("len128", 1'b1, 1'b0);

      // 4: framing error mid-payload, then a clean image
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_data(0, 8'h11);
      send_byte(8'h22, 1'b0);
      check_status("frame_err", 1'b0, 1'b1);
      payload[0] = 8'h33; payload[1] = 8'h44;
      send_image(2);
      check_status("after_frame", 1'b1, 1'b0);

      // 5: sub-half-bit glitch inside the payload, then reset mid-load
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h04, 1'b1);
      send_data(0, 8'h01);
      rx = 1'b0;
      repeat (BP / 4) @(negedge clk);
      rx = 1'b1;
      repeat (2 * BP) @(negedge clk);
      send_data(1, 8'h02);
      check_status("glitch", 1'b0, 1'b0);
      do_reset();
      payload[0] = 8'hAA; payload[1] = 8'hBB;
      send_image(2);
      check_status("reload", 1'b1, 1'b0);

`ifdef REFLET_LOADER_CHECKSUM_EN
      // 6: checksum mismatch then match
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_data(0, 8'h10);
      send_data(1, 8'h20);
      send_byte(8'h31, 1'b1);
      check_status("bad_sum", 1'b0, 1'b1);
      payload[0] = 8'h10; payload[1] = 8'h20;
      send_image(2);
      check_status("good_sum", 1'b1, 1'b0);
`endif

      // Traffic after completion is ignored
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h55, 1'b1);
      check_status("finished_ignores", 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
